// File: rtl/mem_arb_pkg.sv
// Shared definitions for the main-memory arbiter: owner-state encoding and
// default port widths.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_IF   = 2'd1,
        S_DR   = 2'd2,
        S_DW   = 2'd3
    } owner_e;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 20;
    localparam int STARVE_W   = 4;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating fetch-starvation counter with synchronous clear.
// Clear wins over increment; the count sticks at LIMIT until cleared.
module mem_arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                inc_i,
    output logic [STARVE_W-1:0] cnt_o
);

    logic [STARVE_W-1:0] cnt_q, cnt_d;

    // next count: clear, saturate at LIMIT, or step by one
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != STARVE_W'(LIMIT)))
            cnt_d = cnt_q + 1'b1;
    end

    // counter register
    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing the single-port main memory between instruction
// fetch and the data (load/store) port. Data wins by default; read data is
// registered and returned with a one-cycle valid pulse.
// Build option: MEM_ARB_STARVE_GUARD_EN forces a fetch grant after
// STARVE_LIMIT consecutive denied fetch cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_grant_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_valid_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_grant_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_valid_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_wr_en_o,
    input  logic [DATA_W-1:0] mem_q_i
);

    owner_e            state_q, state_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [STARVE_W-1:0] starve_cnt;

    mem_arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (if_grant_o || !if_req_i),
        .inc_i (if_req_i && !if_grant_o),
        .cnt_o (starve_cnt)
    );

    assign force_if = if_req_i && (starve_cnt == STARVE_W'(STARVE_LIMIT));
`else
    assign force_if = 1'b0;
`endif

    // grants: data priority unless fetch is forced; nothing during reset
    always_comb begin
        d_grant_o  = !rst_i && d_req_i && !force_if;
        if_grant_o = !rst_i && if_req_i && (!d_req_i || force_if);
    end

    // memory-side mux driven by whichever port holds the grant
    always_comb begin
        mem_addr_o  = '0;
        mem_data_o  = '0;
        mem_wr_en_o = 1'b0;
        if (if_grant_o) begin
            mem_addr_o = if_addr_i;
        end else if (d_grant_o) begin
            mem_addr_o  = d_addr_i;
            mem_data_o  = d_wdata_i;
            mem_wr_en_o = d_we_i;
        end
    end

    // owner next state: records what this cycle's grant was
    always_comb begin
        state_d = S_IDLE;
        if (d_grant_o)
            state_d = d_we_i ? S_DW : S_DR;
        else if (if_grant_o)
            state_d = S_IF;
    end

    // read-data capture on the granted read edge; otherwise hold
    always_comb begin
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if (if_grant_o)
            if_rdata_d = mem_q_i;
        if (d_grant_o && !d_we_i)
            d_rdata_d = mem_q_i;
    end

    // state and read-data registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // valid pulses follow the owner state; reset in the return cycle
    // discards the pending read
    always_comb begin
        if_valid_o = (state_q == S_IF) && !rst_i;
        d_valid_o  = (state_q == S_DR) && !rst_i;
    end

    assign if_rdata_o = if_rdata_q;
    assign d_rdata_o  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 32 x 20 memory model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 5;
    localparam int DW = 20;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          if_grant, if_valid, d_grant, d_valid, mem_wr_en;
    logic [DW-1:0] if_rdata, d_rdata, mem_data, mem_q;
    logic [AW-1:0] mem_addr;

    logic [DW-1:0] mem [32];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign mem_q = mem[mem_addr];
    always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_data;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(3)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_grant_o (if_grant),
        .if_rdata_o (if_rdata),
        .if_valid_o (if_valid),
        .d_req_i    (d_req),
        .d_we_i     (d_we),
        .d_addr_i   (d_addr),
        .d_wdata_i  (d_wdata),
        .d_grant_o  (d_grant),
        .d_rdata_o  (d_rdata),
        .d_valid_o  (d_valid),
        .mem_addr_o (mem_addr),
        .mem_data_o (mem_data),
        .mem_wr_en_o(mem_wr_en),
        .mem_q_i    (mem_q)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bit exp_if;
        for (int i = 0; i < 32; i++) mem[i] = 20'h10000 + 20'(i);
        rst = 1'b1; if_req = 1'b1; if_addr = 5'd7; d_req = 1'b1; d_we = 1'b1;
        d_addr = 5'd9; d_wdata = 20'h12345;

        // reset: no grants, no writes, cleared outputs
        @(negedge clk); #1;
        check("rst_if_grant", 32'(if_grant), 0);
        check("rst_d_grant", 32'(d_grant), 0);
        check("rst_wr_en", 32'(mem_wr_en), 0);
        @(posedge clk); #1;
        check("rst_if_valid", 32'(if_valid), 0);
        check("rst_d_valid", 32'(d_valid), 0);
        check("rst_if_rdata", 32'(if_rdata), 0);
        check("rst_d_rdata", 32'(d_rdata), 0);
        check("rst_mem9", 32'(mem[9]), 32'h10009);

        // fetch-only read of word 1
        @(negedge clk);
        rst = 1'b0; if_req = 1'b1; if_addr = 5'd1; d_req = 1'b0; d_we = 1'b0;
        #1;
        check("if_grant", 32'(if_grant), 1);
        check("if_d_grant", 32'(d_grant), 0);
        check("if_mem_addr", 32'(mem_addr), 1);
        check("if_wr_en", 32'(mem_wr_en), 0);
        @(posedge clk); #1;
        check("if_valid", 32'(if_valid), 1);
        check("if_rdata", 32'(if_rdata), 32'h10001);
        check("if_dvalid", 32'(d_valid), 0);

        // idle: valid drops, rdata holds
        @(negedge clk); if_req = 1'b0; #1;
        check("idle_mem_addr", 32'(mem_addr), 0);
        @(posedge clk); #1;
        check("idle_if_valid", 32'(if_valid), 0);
        check("idle_if_rdata", 32'(if_rdata), 32'h10001);

        // data write to address 10
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 5'd10; d_wdata = 20'hABCDE; #1;
        check("dw_grant", 32'(d_grant), 1);
        check("dw_wr_en", 32'(mem_wr_en), 1);
        check("dw_mem_addr", 32'(mem_addr), 10);
        check("dw_mem_data", 32'(mem_data), 32'hABCDE);
        @(posedge clk); #1;
        check("dw_d_valid", 32'(d_valid), 0);
        check("dw_mem10", 32'(mem[10]), 32'hABCDE);

        // data read back from address 10
        @(negedge clk); d_we = 1'b0; #1;
        check("dr_grant", 32'(d_grant), 1);
        check("dr_wr_en", 32'(mem_wr_en), 0);
        @(posedge clk); #1;
        check("dr_d_valid", 32'(d_valid), 1);
        check("dr_d_rdata", 32'(d_rdata), 32'hABCDE);
        check("dr_if_valid", 32'(if_valid), 0);

        // write enable without request has no effect
        @(negedge clk);
        d_req = 1'b0; d_we = 1'b1; d_addr = 5'd3; d_wdata = 20'hFFFFF; #1;
        check("nr_d_grant", 32'(d_grant), 0);
        check("nr_wr_en", 32'(mem_wr_en), 0);
        check("nr_mem_data", 32'(mem_data), 0);
        @(posedge clk); #1;
        check("nr_mem3", 32'(mem[3]), 32'h10003);
        check("nr_d_valid", 32'(d_valid), 0);
        check("nr_d_rdata", 32'(d_rdata), 32'hABCDE);

        // contention for 8 cycles
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = 5'd2; d_req = 1'b1; d_we = 1'b0; d_addr = 5'd4;
            #1;
            exp_if = GUARD && (c % 4 == 0);
            check($sformatf("ct%0d_if_grant", c), 32'(if_grant), 32'(exp_if));
            check($sformatf("ct%0d_d_grant", c), 32'(d_grant), 32'(!exp_if));
            @(posedge clk); #1;
            if (exp_if) begin
                check($sformatf("ct%0d_if_valid", c), 32'(if_valid), 1);
                check($sformatf("ct%0d_if_rdata", c), 32'(if_rdata), 32'h10002);
            end else begin
                check($sformatf("ct%0d_d_valid", c), 32'(d_valid), 1);
                check($sformatf("ct%0d_d_rdata", c), 32'(d_rdata), 32'h10004);
            end
        end

        // reset in the cycle after a data read grant
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 5'd5; #1;
        check("rm_d_grant", 32'(d_grant), 1);
        @(posedge clk);
        @(negedge clk); rst = 1'b1; #1;
        check("rm_d_grant_rst", 32'(d_grant), 0);
        check("rm_if_grant_rst", 32'(if_grant), 0);
        check("rm_d_valid_rst", 32'(d_valid), 0);
        @(posedge clk); #1;
        check("rm_d_valid", 32'(d_valid), 0);
        check("rm_d_rdata", 32'(d_rdata), 0);
        check("rm_if_rdata", 32'(if_rdata), 0);
        check("rm_state", 32'(dut.state_q), 32'(S_IDLE));

        // recovery: fetch works after reset release
        @(negedge clk); rst = 1'b0; d_req = 1'b0; if_req = 1'b1; if_addr = 5'd10; #1;
        check("rc_if_grant", 32'(if_grant), 1);
        @(posedge clk); #1;
        check("rc_if_rdata", 32'(if_rdata), 32'hABCDE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
